// File: rtl/main_control_fsm.sv
// Multicycle processor main control FSM.
// Moore machine sequencing instruction fetch, decode, memory access,
// execute and writeback. Outputs depend on the current state only, except
// for three cases. IRWrite/PCUpdate in FETCH follow mem_ready. illegal_instr
// in DECODE follows the opcode. Reset gates off every strobe.
module main_control_fsm (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic [1:0] ALUOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCUpdate,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       Branch,
  output logic       illegal_instr,
  output logic [3:0] state
);

  // State encodings
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BRANCH   = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  // Supported opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  // ALUOp classes
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_R   = 2'b10;
  localparam logic [1:0] ALU_I   = 2'b11;

  // Operand A selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  // Operand B selects
  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  // Result selects
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_RDATA  = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  logic [3:0] state_q, state_d;
  // Opcode class latched at DECODE: 1 = store, 0 = load (or not a memory op)
  logic       store_q, store_d;

  assign state = state_q;

  // State and opcode-class registers; asynchronous reset back to FETCH
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      store_q <= 1'b0;
    end else begin
      state_q <= state_d;
      store_q <= store_d;
    end
  end

  // Next-state logic; the opcode is consulted only in DECODE
  always_comb begin
    state_d = S_FETCH;
    store_d = store_q;
    case (state_q)
      S_FETCH: state_d = mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        store_d = (opcode == OP_STORE);
        case (opcode)
          OP_LOAD,
          OP_STORE:  state_d = S_MEMADR;
          OP_RTYPE:  state_d = S_EXECUTER;
          OP_ITYPE:  state_d = S_EXECUTEI;
          OP_BRANCH: state_d = S_BRANCH;
          OP_JAL:    state_d = S_JAL;
          default:   state_d = S_FETCH;
        endcase
      end
      S_MEMADR:   state_d = store_q ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  // Output decode per state
  always_comb begin
    mem_req       = 1'b0;
    ALUOp         = ALU_ADD;
    ALUSrcA       = SRCA_PC;
    ALUSrcB       = SRCB_RS2;
    ResultSrc     = RES_ALUOUT;
    AdrSrc        = 1'b0;
    IRWrite       = 1'b0;
    PCUpdate      = 1'b0;
    RegWrite      = 1'b0;
    MemWrite      = 1'b0;
    Branch        = 1'b0;
    illegal_instr = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALU_ADD;
        ResultSrc = RES_ALU;
        IRWrite   = mem_ready;
        PCUpdate  = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
        case (opcode)
          OP_LOAD, OP_STORE, OP_RTYPE,
          OP_ITYPE, OP_BRANCH, OP_JAL: illegal_instr = 1'b0;
          default:                     illegal_instr = 1'b1;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_ADD;
      end
      S_MEMREAD: begin
        mem_req   = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
      end
      S_MEMWB: begin
        ResultSrc = RES_RDATA;
        RegWrite  = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        AdrSrc    = 1'b1;
        ResultSrc = RES_ALUOUT;
        MemWrite  = 1'b1;
      end
      S_EXECUTER: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_RS2;
        ALUOp   = ALU_R;
      end
      S_EXECUTEI: begin
        ALUSrcA = SRCA_RS1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = ALU_I;
      end
      S_ALUWB: begin
        ResultSrc = RES_ALUOUT;
        RegWrite  = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA   = SRCA_RS1;
        ALUSrcB   = SRCB_RS2;
        ALUOp     = ALU_SUB;
        ResultSrc = RES_ALUOUT;
        Branch    = 1'b1;
      end
      S_JAL: begin
        ALUSrcA   = SRCA_OLDPC;
        ALUSrcB   = SRCB_FOUR;
        ALUOp     = ALU_ADD;
        ResultSrc = RES_ALUOUT;
        PCUpdate  = 1'b1;
      end
      default: ;
    endcase
    // The state register already reads FETCH while rst_n is low, so the
    // selects carry FETCH values; only the strobes need masking here.
    if (!rst_n) begin
      mem_req       = 1'b0;
      IRWrite       = 1'b0;
      PCUpdate      = 1'b0;
      RegWrite      = 1'b0;
      MemWrite      = 1'b0;
      Branch        = 1'b0;
      illegal_instr = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Directed testbench for main_control_fsm with hand-computed expected outputs.
module tb_main_control_fsm;

  logic       clk;
  logic       rst_n;
  logic [6:0] opcode;
  logic       mem_ready;
  logic       mem_req;
  logic [1:0] ALUOp, ALUSrcA, ALUSrcB, ResultSrc;
  logic       AdrSrc, IRWrite, PCUpdate, RegWrite, MemWrite, Branch, illegal_instr;
  logic [3:0] state;

  main_control_fsm u_dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .mem_ready     (mem_ready),
    .mem_req       (mem_req),
    .ALUOp         (ALUOp),
    .ALUSrcA       (ALUSrcA),
    .ALUSrcB       (ALUSrcB),
    .ResultSrc     (ResultSrc),
    .AdrSrc        (AdrSrc),
    .IRWrite       (IRWrite),
    .PCUpdate      (PCUpdate),
    .RegWrite      (RegWrite),
    .MemWrite      (MemWrite),
    .Branch        (Branch),
    .illegal_instr (illegal_instr),
    .state         (state)
  );

  // Packed view of all outputs except state:
  // [15] mem_req [14:13] ALUOp [12:11] ALUSrcA [10:9] ALUSrcB [8:7] ResultSrc
  // [6] AdrSrc [5] IRWrite [4] PCUpdate [3] RegWrite [2] MemWrite [1] Branch [0] illegal_instr
  logic [15:0] outs;
  assign outs = {mem_req, ALUOp, ALUSrcA, ALUSrcB, ResultSrc, AdrSrc,
                 IRWrite, PCUpdate, RegWrite, MemWrite, Branch, illegal_instr};

  localparam logic [15:0] E_RST   = 16'b0_00_00_10_10_0_0_0_0_0_0_0;
  localparam logic [15:0] E_F1    = 16'b1_00_00_10_10_0_1_1_0_0_0_0;
  localparam logic [15:0] E_F0    = 16'b1_00_00_10_10_0_0_0_0_0_0_0;
  localparam logic [15:0] E_DEC   = 16'b0_00_01_01_00_0_0_0_0_0_0_0;
  localparam logic [15:0] E_DECIL = 16'b0_00_01_01_00_0_0_0_0_0_0_1;
  localparam logic [15:0] E_MADR  = 16'b0_00_10_01_00_0_0_0_0_0_0_0;
  localparam logic [15:0] E_MRD   = 16'b1_00_00_00_00_1_0_0_0_0_0_0;
  localparam logic [15:0] E_MWB   = 16'b0_00_00_00_01_0_0_0_1_0_0_0;
  localparam logic [15:0] E_MWR   = 16'b1_00_00_00_00_1_0_0_0_1_0_0;
  localparam logic [15:0] E_EXR   = 16'b0_10_10_00_00_0_0_0_0_0_0_0;
  localparam logic [15:0] E_EXI   = 16'b0_11_10_01_00_0_0_0_0_0_0_0;
  localparam logic [15:0] E_AWB   = 16'b0_00_00_00_00_0_0_0_1_0_0_0;
  localparam logic [15:0] E_BR    = 16'b0_01_10_00_00_0_0_0_0_0_1_0;
  localparam logic [15:0] E_JAL   = 16'b0_00_01_10_00_0_0_1_0_0_0_0;

  localparam logic [6:0] OP_X = 7'b1111111;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, act, exp);
    end
  endtask

  // Drive inputs for the current cycle, then check state/outputs mid-cycle
  task automatic apply_chk(input string tag, input logic [6:0] op, input logic mr,
                           input logic [3:0] es, input logic [15:0] eo);
    opcode    = op;
    mem_ready = mr;
    #1;
    check_eq({tag, ".state"}, {28'd0, state}, {28'd0, es});
    check_eq({tag, ".out"}, {16'd0, outs}, {16'd0, eo});
    check_eq({tag, ".excl"}, ($countones({RegWrite, MemWrite, IRWrite}) <= 1) ? 32'd1 : 32'd0, 32'd1);
  endtask

  task automatic adv();
    @(posedge clk);
    #2;
  endtask

  task automatic cyc(input string tag, input logic [6:0] op, input logic mr,
                     input logic [3:0] es, input logic [15:0] eo);
    apply_chk(tag, op, mr, es, eo);
    adv();
  endtask

  initial begin
    rst_n     = 1'b0;
    opcode    = OP_X;
    mem_ready = 1'b1;
    #3;
    check_eq("rst.state", {28'd0, state}, 32'd0);
    check_eq("rst.out", {16'd0, outs}, {16'd0, E_RST});
    #9;
    rst_n = 1'b1;  // t=12, before the edge at 15

    // R-type
    cyc("r.f",   OP_X,         1'b1, 4'd0, E_F1);
    cyc("r.d",   7'b0110011,   1'b1, 4'd1, E_DEC);
    cyc("r.ex",  OP_X,         1'b1, 4'd6, E_EXR);
    cyc("r.wb",  OP_X,         1'b1, 4'd8, E_AWB);

    // Load with fetch wait and two memory wait cycles; opcode flips to store after DECODE
    cyc("ld.f0", OP_X,         1'b0, 4'd0, E_F0);
    cyc("ld.f1", OP_X,         1'b1, 4'd0, E_F1);
    cyc("ld.d",  7'b0000011,   1'b1, 4'd1, E_DEC);
    cyc("ld.ma", 7'b0100011,   1'b1, 4'd2, E_MADR);
    cyc("ld.r0", 7'b0100011,   1'b0, 4'd3, E_MRD);
    cyc("ld.r1", OP_X,         1'b0, 4'd3, E_MRD);
    cyc("ld.r2", OP_X,         1'b1, 4'd3, E_MRD);
    cyc("ld.wb", OP_X,         1'b1, 4'd4, E_MWB);

    // Store; opcode flips to load after DECODE
    cyc("st.f",  OP_X,         1'b1, 4'd0, E_F1);
    cyc("st.d",  7'b0100011,   1'b1, 4'd1, E_DEC);
    cyc("st.ma", 7'b0000011,   1'b1, 4'd2, E_MADR);
    cyc("st.w",  OP_X,         1'b1, 4'd5, E_MWR);

    // Branch
    cyc("br.f",  OP_X,         1'b1, 4'd0, E_F1);
    cyc("br.d",  7'b1100011,   1'b1, 4'd1, E_DEC);
    cyc("br.b",  OP_X,         1'b1, 4'd9, E_BR);

    // I-type
    cyc("i.f",   OP_X,         1'b1, 4'd0, E_F1);
    cyc("i.d",   7'b0010011,   1'b1, 4'd1, E_DEC);
    cyc("i.ex",  OP_X,         1'b1, 4'd7, E_EXI);
    cyc("i.wb",  OP_X,         1'b1, 4'd8, E_AWB);

    // JAL
    cyc("j.f",   OP_X,         1'b1, 4'd0, E_F1);
    cyc("j.d",   7'b1101111,   1'b1, 4'd1, E_DEC);
    cyc("j.j",   OP_X,         1'b1, 4'd10, E_JAL);
    cyc("j.wb",  OP_X,         1'b1, 4'd8, E_AWB);

    // Illegal opcode
    cyc("il.f",  OP_X,         1'b1, 4'd0, E_F1);
    cyc("il.d",  7'b1111111,   1'b1, 4'd1, E_DECIL);

    // Store stalled in MEMWRITE, then reset mid-cycle
    cyc("rs.f",  OP_X,         1'b1, 4'd0, E_F1);
    cyc("rs.d",  7'b0100011,   1'b1, 4'd1, E_DEC);
    cyc("rs.ma", OP_X,         1'b0, 4'd2, E_MADR);
    cyc("rs.w0", OP_X,         1'b0, 4'd5, E_MWR);
    apply_chk("rs.w1", OP_X,   1'b0, 4'd5, E_MWR);
    #1;
    rst_n = 1'b0;
    #1;
    check_eq("rs.async.state", {28'd0, state}, 32'd0);
    check_eq("rs.async.out", {16'd0, outs}, {16'd0, E_RST});
    adv();
    check_eq("rs.hold.state", {28'd0, state}, 32'd0);
    check_eq("rs.hold.out", {16'd0, outs}, {16'd0, E_RST});
    rst_n = 1'b1;

    // Normal fetch resumes; a load must follow (class register was cleared)
    cyc("rs2.f",  OP_X,        1'b1, 4'd0, E_F1);
    cyc("rs2.d",  7'b0000011,  1'b1, 4'd1, E_DEC);
    cyc("rs2.ma", OP_X,        1'b1, 4'd2, E_MADR);
    cyc("rs2.r",  OP_X,        1'b1, 4'd3, E_MRD);
    cyc("rs2.wb", OP_X,        1'b1, 4'd4, E_MWB);
    cyc("rs2.f2", OP_X,        1'b1, 4'd0, E_F1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 clk  input  1  single clock; all state updates occur on its rising edge.
REQ-002 rst_n  input  1  reset; asynchronous and active-low.
REQ-003 opcode  input  7  opcode field instr[6:0] from the instruction register; sampled in DECODE only.
REQ-004 mem_ready  input  1  memory handshake; high means the current access completes this cycle.
REQ-005 mem_req  output  1  memory access request; high in FETCH, MEMREAD and MEMWRITE.
REQ-006 ALUOp  output  2  ALU class, consumed by alu_control: 00 add, 01 sub/branch, 10 R-type, 11 I-type.
REQ-007 ALUSrcA  output  2  ALU operand A select: 00 PC, 01 OldPC, 10 rs1.
REQ-008 ALUSrcB  output  2  ALU operand B select: 00 rs2, 01 imm, 10 constant 4.
REQ-009 ResultSrc  output  2  result select: 00 ALUOut, 01 read data, 10 ALU result.
REQ-010 AdrSrc  output  1  memory address select: 0 PC, 1 ALUOut.
REQ-011 IRWrite, PCUpdate, RegWrite, MemWrite, Branch  output  1 each  write strobes.
REQ-012 illegal_instr  output  1  one-cycle pulse when an unsupported opcode is decoded.
REQ-013 state  output  4  current state encoding, for debug and verification.

Function
REQ-014 The block SHALL be a Moore FSM with states FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9, JAL=10.
REQ-015 Any output not listed for a state SHALL be 0.
REQ-016 FETCH outputs: mem_req=1, AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite = PCUpdate = mem_ready.
  - Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
REQ-017 DECODE outputs: ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BRANCH
  - 1101111 -> JAL
  - any other opcode -> FETCH, with illegal_instr=1 for that cycle.
REQ-018 MEMADR outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Next state: MEMREAD if the opcode latched at DECODE was a load, MEMWRITE if it was a store.
REQ-019 The opcode class SHALL be captured in an internal register at DECODE, so later opcode changes do not affect MEMADR.
REQ-020 MEMREAD outputs: mem_req=1, AdrSrc=1, ResultSrc=00. Stay while mem_ready=0; go to MEMWB on mem_ready=1.
REQ-021 MEMWB outputs: ResultSrc=01, RegWrite=1. Next state: FETCH.
REQ-022 MEMWRITE outputs: mem_req=1, AdrSrc=1, ResultSrc=00, MemWrite=1. MemWrite SHALL be held until mem_ready=1, then go to FETCH.
REQ-023 EXECUTER outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Next state: ALUWB.
REQ-024 EXECUTEI outputs: ALUSrcA=10, ALUSrcB=01, ALUOp=11. Next state: ALUWB.
REQ-025 ALUWB outputs: ResultSrc=00, RegWrite=1. Next state: FETCH.
REQ-026 BRANCH outputs: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Next state: FETCH.
REQ-027 JAL outputs: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Next state: ALUWB.
REQ-028 Unused encodings 11-15 SHALL go to FETCH on the next edge, with all outputs 0 while in them.
REQ-029 Cycle counts with mem_ready tied high:
  - R/I-type and JAL: 4 cycles.
  - load: 5 cycles.
  - store: 4 cycles.
  - branch: 3 cycles.
  - Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds exactly one cycle.
REQ-030 At most one of RegWrite, MemWrite, IRWrite SHALL be high in any cycle.

Reset
REQ-031 While rst_n=0, the block SHALL immediately force state=FETCH and the internal opcode class to 0, without waiting for a clock edge.
REQ-032 While rst_n=0, mem_req, IRWrite, PCUpdate, RegWrite, MemWrite, Branch and illegal_instr SHALL all be 0.
REQ-033 While rst_n=0, the mux selects SHALL carry FETCH values: ALUOp=00, ALUSrcA=00, ALUSrcB=10, ResultSrc=10, AdrSrc=0.
REQ-034 Reset asserted in any state, including during a pending memory wait, SHALL abandon the instruction with no further strobes.
REQ-035 After rst_n rises, the first clock edge SHALL evaluate FETCH normally.

Verification
REQ-036 R-type flow: opcode=0110011, mem_ready=1 -> states 0,1,6,8,0; ALUOp=10 in EXECUTER; RegWrite=1 only in ALUWB.
REQ-037 Load with memory wait: opcode=0000011, mem_ready low for 2 cycles in MEMREAD -> states 0,1,2,3,3,3,4,0; RegWrite=1 with ResultSrc=01 once.
REQ-038 Store: opcode=0100011 -> MemWrite=1 for exactly one cycle with AdrSrc=1; RegWrite is never asserted.
REQ-039 Branch and I-type: opcode=1100011 -> ALUOp=01 and Branch=1 in state 9; opcode=0010011 -> ALUOp=11 in state 7.
REQ-040 Illegal opcode 1111111 -> illegal_instr=1 for one cycle in DECODE, then FETCH; no write strobes.
REQ-041 Reset in MEMWRITE with mem_ready=0 -> state=0 and MemWrite=0 before the next clock edge; normal FETCH resumes after release.
